adc_capture_buf: RTL and testbench

Triggered capture buffer that sits directly downstream of the adc082s021 sample stage. It records ADC conversion results into a circular RAM, keeping a fixed number of pre-trigger samples. On a trigger it fills the remainder of the buffer and freezes. The debug SPI command decoder then reads the frozen record out oldest-first.

---
 rtl/adc_capture_buf_if.sv | 38 +++
 rtl/adc_capture_buf.sv | 153 +++++++++++++++
 tb/tb_adc_capture_buf.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_buf_if.sv
`default_nettype none
// ============================================================================
//  Module      : adc_capture_buf_if
//  Description : Bundles the sample, trigger-control, status and readout
//                signals of the ADC capture buffer.
//                master : sample source / controller / SPI readout side
//                slave  : the capture buffer itself
//  Signals     : sample_valid, sample, arm, trig, rd_start, rd_next
//                -> towards buffer
//                busy, triggered, done, rd_data
//                -> from buffer
//  Revision    : 1.0 - initial release
// ============================================================================
interface adc_capture_buf_if #(
    parameter int WIDTH = 12
);
    logic             sample_valid;
    logic [WIDTH-1:0] sample;
    logic             arm;
    logic             trig;
    logic             busy;
    logic             triggered;
    logic             done;
    logic             rd_start;
    logic             rd_next;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output sample_valid, sample, arm, trig, rd_start, rd_next,
        input  busy, triggered, done, rd_data
    );

    modport slave (
        input  sample_valid, sample, arm, trig, rd_start, rd_next,
        output busy, triggered, done, rd_data
    );
endinterface
`default_nettype wire

// File: rtl/adc_capture_buf.sv
`default_nettype none
// ============================================================================
//  Module      : adc_capture_buf
//  Description : Triggered capture buffer downstream of the ADC sample
//                stage. It records samples into a circular RAM, keeps PRE
//                pre-trigger samples, fills the rest of the buffer after a
//                trigger, and then freezes. The frozen record is read out
//                oldest-first through rd_start / rd_next.
//  Ports       : clk    - system clock, all logic on posedge
//                reset  - synchronous, active-high reset
//                bus    - adc_capture_buf_if.slave
//                         (sample/arm/trig/readout in, status/rd_data out)
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_capture_buf #(
    parameter int WIDTH      = 12,
    parameter int DEPTH_LOG2 = 8,
    parameter int PRE        = 64
) (
    input wire                clk,
    input wire                reset,
    adc_capture_buf_if.slave  bus
);

    localparam int c_DEPTH = 2 ** DEPTH_LOG2;
    localparam int c_CW    = DEPTH_LOG2 + 1;

    localparam logic [c_CW-1:0] c_PRE_CNT  = c_CW'(PRE);
    localparam logic [c_CW-1:0] c_POST_CNT = c_CW'(c_DEPTH - PRE);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_PRE   = 3'd1;
    localparam logic [2:0] c_ST_ARMED = 3'd2;
    localparam logic [2:0] c_ST_POST  = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    logic [2:0]            r_state;
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [c_CW-1:0]       r_pre_cnt;
    logic [c_CW-1:0]       r_post_cnt;
    logic [WIDTH-1:0]      r_mem [c_DEPTH];
    logic [WIDTH-1:0]      r_rd_data;

    logic                  w_capturing;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [DEPTH_LOG2-1:0] w_rd_addr;
    logic [DEPTH_LOG2-1:0] w_wptr_inc;
    logic [c_CW-1:0]       w_pre_cnt_inc;
    logic [c_CW-1:0]       w_post_cnt_inc;

    assign w_capturing = (r_state == c_ST_PRE) || (r_state == c_ST_ARMED) ||
                         (r_state == c_ST_POST);

    // arm outranks everything, so a sample or read in the arm cycle is dropped
    assign w_wr_en = !reset && !bus.arm && bus.sample_valid && w_capturing;
    assign w_rd_en = !reset && !bus.arm && (r_state == c_ST_DONE) &&
                     (bus.rd_start || bus.rd_next);

    // After freezing, wptr points at the oldest sample of the record
    assign w_rd_addr      = bus.rd_start ? r_wptr : r_rptr;
    assign w_wptr_inc     = r_wptr + 1'b1;
    assign w_pre_cnt_inc  = r_pre_cnt + 1'b1;
    assign w_post_cnt_inc = r_post_cnt + 1'b1;

    // Status outputs are decodes of the registered state
    assign bus.busy      = w_capturing;
    assign bus.triggered = (r_state == c_ST_POST) || (r_state == c_ST_DONE);
    assign bus.done      = (r_state == c_ST_DONE);
    assign bus.rd_data   = r_rd_data;

    // Control state machine, pointers and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_pre_cnt  <= '0;
            r_post_cnt <= '0;
        end else if (bus.arm) begin
            // wptr is left alone; the ring simply keeps rolling
            r_state    <= c_ST_PRE;
            r_pre_cnt  <= '0;
            r_post_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_PRE: begin
                    if (bus.sample_valid) begin
                        r_wptr    <= w_wptr_inc;
                        r_pre_cnt <= w_pre_cnt_inc;
                        if (w_pre_cnt_inc == c_PRE_CNT) begin
                            r_state <= c_ST_ARMED;
                        end
                    end
                end
                c_ST_ARMED: begin
                    if (bus.sample_valid) begin
                        r_wptr <= w_wptr_inc;
                    end
                    if (bus.trig) begin
                        if (bus.sample_valid) begin
                            // The trigger-cycle sample is post sample 0
                            r_post_cnt <= {{(c_CW-1){1'b0}}, 1'b1};
                            r_state    <= (c_POST_CNT == {{(c_CW-1){1'b0}}, 1'b1}) ?
                                          c_ST_DONE : c_ST_POST;
                        end else begin
                            r_post_cnt <= '0;
                            r_state    <= c_ST_POST;
                        end
                    end
                end
                c_ST_POST: begin
                    if (bus.sample_valid) begin
                        r_wptr     <= w_wptr_inc;
                        r_post_cnt <= w_post_cnt_inc;
                        if (w_post_cnt_inc == c_POST_CNT) begin
                            r_state <= c_ST_DONE;
                        end
                    end
                end
                c_ST_DONE: begin
                    if (bus.rd_start) begin
                        r_rptr <= w_wptr_inc;
                    end else if (bus.rd_next) begin
                        r_rptr <= r_rptr + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    // Sample RAM write port; no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= bus.sample;
        end
    end

    // Registered read port; reads only happen in DONE, never alongside a write
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (w_rd_en) begin
            r_rd_data <= r_mem[w_rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_capture_buf
//  Description : Self-checking bench for adc_capture_buf (DEPTH=16, PRE=4).
//                A scenario table drives directed captures, hand sequences
//                cover readout wrap / priority / re-arm, and a random phase
//                runs against a record-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_capture_buf;

    localparam int W     = 12;
    localparam int DL    = 4;
    localparam int DEPTH = 16;
    localparam int PRE   = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    adc_capture_buf_if #(.WIDTH(W)) bus ();

    adc_capture_buf #(
        .WIDTH      (W),
        .DEPTH_LOG2 (DL),
        .PRE        (PRE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: capture progress and the last DEPTH written samples
    bit m_active = 0;
    bit m_trig   = 0;
    bit m_done   = 0;
    bit m_kvalid = 0;
    int m_nw     = 0;
    int m_npost  = 0;
    int m_rd     = 0;
    int m_k      = 0;
    int rec[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_write(input int v);
        rec.push_back(v);
        if (rec.size() > DEPTH) void'(rec.pop_front());
    endtask

    // One clock: drive inputs, advance model, compare at the falling edge
    task automatic cyc(input bit rst, input bit a, input bit sv, input int smp,
                       input bit tr, input bit rs, input bit rn);
        bit armed_before;
        logic [31:0] sv32;
        sv32 = smp;
        reset            = rst;
        bus.arm          = a;
        bus.sample_valid = sv;
        bus.sample       = sv32[W-1:0];
        bus.trig         = tr;
        bus.rd_start     = rs;
        bus.rd_next      = rn;
        @(posedge clk);
        if (rst) begin
            m_active = 0; m_trig = 0; m_done = 0; m_rd = 0; m_kvalid = 0;
        end else if (a) begin
            m_active = 1; m_trig = 0; m_done = 0; m_nw = 0; m_npost = 0; m_kvalid = 0;
        end else if (m_active) begin
            if (!m_trig) begin
                armed_before = (m_nw >= PRE);
                if (sv) begin
                    model_write(smp);
                    m_nw++;
                end
                if (tr && armed_before) begin
                    m_trig  = 1;
                    m_npost = sv ? 1 : 0;
                end
            end else if (sv) begin
                model_write(smp);
                m_npost++;
            end
            if (m_trig && m_npost == DEPTH - PRE) begin
                m_active = 0;
                m_done   = 1;
            end
        end else if (m_done) begin
            if (rs) begin
                m_rd = rec[0]; m_k = 1; m_kvalid = 1;
            end else if (rn) begin
                m_rd = rec[m_k]; m_k = (m_k + 1) % DEPTH;
            end
        end
        @(negedge clk);
        chk("busy",      int'(bus.busy),      int'(m_active));
        chk("triggered", int'(bus.triggered), int'(m_trig));
        chk("done",      int'(bus.done),      int'(m_done));
        chk("rd_data",   int'(bus.rd_data),   m_rd);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Seven idle clocks then one sample strobe (sample_valid every 8 clk)
    task automatic gap_and_sample(input int v, input bit tr_with, input bit tr_gap);
        for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, tr_gap && (i == 3), 0, 0);
        cyc(0, 0, 1, v, tr_with, 0, 0);
    endtask

    typedef struct {
        int trig_a;     // ignored trigger sample index (-1 for none)
        int trig_b;     // accepted trigger sample index
        bit between;    // trig_b asserted in the gap before that sample
        bit rst_mid;    // first abort a capture with reset in POST
        int exp_first;  // oldest sample in the frozen record
    } scen_t;

    task automatic run_scen(input scen_t sc);
        int last;
        if (sc.rst_mid) begin
            cyc(0, 1, 0, 0, 0, 0, 0);
            for (int s = 0; s <= 13; s++) gap_and_sample(s, s == 10, 0);
            chk("mid_post_triggered", int'(bus.triggered), 1);
            cyc(1, 0, 0, 0, 0, 0, 0);
            chk("rst_busy",      int'(bus.busy),      0);
            chk("rst_triggered", int'(bus.triggered), 0);
            chk("rst_done",      int'(bus.done),      0);
            chk("rst_rd_data",   int'(bus.rd_data),   0);
        end
        cyc(0, 1, 0, 0, 0, 0, 0);
        chk("arm_busy", int'(bus.busy), 1);
        chk("arm_done", int'(bus.done), 0);
        last = -1;
        for (int s = 0; s < 40; s++) begin
            gap_and_sample(s, !sc.between && (s == sc.trig_a || s == sc.trig_b),
                           sc.between && (s == sc.trig_b));
            chk("trig_seen", int'(bus.triggered), int'(s >= sc.trig_b));
            if (bus.done) begin
                last = s;
                break;
            end
            chk("busy_in_capture", int'(bus.busy), 1);
        end
        chk("done_after_sample", last, sc.exp_first + DEPTH - 1);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("readout_first", int'(bus.rd_data), sc.exp_first);
        for (int i = 1; i < DEPTH; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1);
            chk("readout_seq", int'(bus.rd_data), sc.exp_first + i);
        end
    endtask

    initial begin
        scen_t tbl[4];
        bit a, sv, tr, rs, rn, rst;

        tbl[0] = '{trig_a: -1, trig_b: 5,  between: 0, rst_mid: 1, exp_first: 1};
        tbl[1] = '{trig_a: -1, trig_b: 10, between: 0, rst_mid: 0, exp_first: 6};
        tbl[2] = '{trig_a: 2,  trig_b: 7,  between: 0, rst_mid: 0, exp_first: 3};
        tbl[3] = '{trig_a: -1, trig_b: 10, between: 1, rst_mid: 0, exp_first: 6};

        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("init_busy",      int'(bus.busy),      0);
        chk("init_triggered", int'(bus.triggered), 0);
        chk("init_done",      int'(bus.done),      0);
        chk("init_rd_data",   int'(bus.rd_data),   0);
        // sample_valid / trig ignored in IDLE
        cyc(0, 0, 1, 55, 1, 0, 0);
        chk("idle_ignores", int'(bus.busy) + int'(bus.triggered), 0);

        for (int t = 0; t < 4; t++) run_scen(tbl[t]);

        // Readout wrap: record is 6..21
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("wrap_first", int'(bus.rd_data), 6);
        for (int i = 1; i <= DEPTH; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1);
            chk("wrap_seq", int'(bus.rd_data), 6 + (i % DEPTH));
        end
        cyc(0, 0, 0, 0, 0, 1, 1);
        chk("start_beats_next", int'(bus.rd_data), 6);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("next_after_start", int'(bus.rd_data), 7);

        // Re-arm from DONE: stale record must not be readable
        cyc(0, 1, 0, 0, 0, 1, 0);
        chk("rearm_done", int'(bus.done), 0);
        chk("rearm_busy", int'(bus.busy), 1);
        chk("rearm_no_read", int'(bus.rd_data), 7);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("pre_read_ignored", int'(bus.rd_data), 7);
        for (int s = 0; s < 4; s++) begin
            gap_and_sample(100 + s, s >= 2, 0);
            chk("pre_trig_ignored", int'(bus.triggered), 0);
            chk("pre_busy", int'(bus.busy), 1);
        end
        gap_and_sample(104, 1, 0);
        chk("armed_trig", int'(bus.triggered), 1);
        for (int s = 5; s < DEPTH; s++) begin
            chk("post_not_done", int'(bus.done), 0);
            gap_and_sample(100 + s, 0, 0);
        end
        chk("rearm_done_final", int'(bus.done), 1);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("fresh_record", int'(bus.rd_data), 100);

        // Reads in IDLE leave rd_data alone
        cyc(1, 0, 0, 0, 0, 0, 0);
        chk("idle_rd_zero", int'(bus.rd_data), 0);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("idle_rd_next", int'(bus.rd_data), 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        chk("idle_rd_start", int'(bus.rd_data), 0);

        // Randomized phase against the reference model
        for (int c = 0; c < 6000; c++) begin
            rst = ($urandom_range(0, 1999) == 0);
            if (m_done)        a = ($urandom_range(0, 39) == 0);
            else if (m_active) a = ($urandom_range(0, 399) == 0);
            else               a = ($urandom_range(0, 19) == 0);
            sv = ($urandom_range(0, 1) == 1);
            tr = ($urandom_range(0, 7) == 0);
            if (m_done) rs = !m_kvalid || ($urandom_range(0, 7) == 0);
            else        rs = ($urandom_range(0, 15) == 0);
            rn = ($urandom_range(0, 1) == 1);
            cyc(rst, a, sv, int'($urandom_range(0, 4095)), tr, rs, rn);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
